// File: rtl/program_loader_if.sv
// Byte-stream in / program-memory write port out for the program loader.
// The master side feeds start/bytes; the slave side (the loader) drives the write port and status.
interface program_loader_if #(
  parameter int AB = 11,
  parameter int DB = 16
) ();
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          we;
  logic [AB-1:0] waddr;
  logic [DB-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AB:0]   words_written;

  modport master (
    output start, rx_data, rx_done,
    input  we, waddr, wdata, busy, done, err, words_written
  );

  modport slave (
    input  start, rx_data, rx_done,
    output we, waddr, wdata, busy, done, err, words_written
  );
endinterface

// File: rtl/program_loader.sv
// Parses a big-endian word count plus big-endian 16-bit words from a byte stream
// and writes them to consecutive program-memory addresses starting at 0.
module program_loader #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input logic            clk,
  input logic            reset,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [15:0] MAX_N = 16'(1 << AB);

  state_t        state, state_nxt;
  logic [15:0]   len, len_nxt;
  logic [7:0]    hi_byte, hi_byte_nxt;
  logic [AB-1:0] addr, addr_nxt;
  logic          we, we_nxt;
  logic [AB-1:0] waddr, waddr_nxt;
  logic [DB-1:0] wdata, wdata_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          err, err_nxt;
  logic [AB:0]   words, words_nxt;

  logic [15:0]   len_rx;
  logic [AB:0]   words_inc;

  assign len_rx    = {len[15:8], bus.rx_data};
  assign words_inc = words + {{AB{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      hi_byte <= '0;
      addr    <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      words   <= '0;
    end else begin
      state   <= state_nxt;
      len     <= len_nxt;
      hi_byte <= hi_byte_nxt;
      addr    <= addr_nxt;
      we      <= we_nxt;
      waddr   <= waddr_nxt;
      wdata   <= wdata_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      words   <= words_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    hi_byte_nxt = hi_byte;
    addr_nxt    = addr;
    we_nxt      = 1'b0;
    waddr_nxt   = waddr;
    wdata_nxt   = wdata;
    busy_nxt    = busy;
    done_nxt    = done;
    err_nxt     = err;
    words_nxt   = words;

    case (state)
      // Bytes arriving while idle, or together with start, are dropped.
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = LEN_HI;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          words_nxt = '0;
          addr_nxt  = '0;
        end
      end
      LEN_HI: begin
        if (bus.rx_done) begin
          len_nxt[15:8] = bus.rx_data;
          state_nxt     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (bus.rx_done) begin
          len_nxt[7:0] = bus.rx_data;
          if (len_rx == 16'd0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else if (len_rx > MAX_N) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (bus.rx_done) begin
          hi_byte_nxt = bus.rx_data;
          state_nxt   = DATA_LO;
        end
      end
      DATA_LO: begin
        if (bus.rx_done) begin
          we_nxt    = 1'b1;
          waddr_nxt = addr;
          wdata_nxt = {hi_byte, bus.rx_data};
          words_nxt = words_inc;
          // The final word leaves the counter at N-1 so it never wraps at N = 2^AB.
          if (16'(words_inc) == len) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            addr_nxt  = addr + {{(AB-1){1'b0}}, 1'b1};
            state_nxt = DATA_HI;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.we            = we;
  assign bus.waddr         = waddr;
  assign bus.wdata         = wdata;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.err           = err;
  assign bus.words_written = words;

endmodule

// File: doc/program_loader.md
# program_loader

Sequential writer for the 2048 x 16 program memory. It receives a byte stream from the serial receiver (one-cycle `rx_done` strobe with `rx_data`) and parses a 16-bit big-endian word count followed by that many big-endian instruction words. It writes the words to consecutive program-memory addresses starting at 0, producing one write-enable pulse per word. It sits between the UART receive path and the program memory write port, and holds the processor off (`busy`) while loading.

## Interface

Parameters:
- `AB`, 11: program-memory address width.
- `DB`, 16: instruction word width. Fixed at 2 bytes; only 16 is supported.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a load.
- `rx_data`  in  8: received byte; valid only when `rx_done` = 1.
- `rx_done`  in  1: one-cycle byte-valid strobe.
- `we`  out  1: program-memory write enable, one cycle per word.
- `waddr`  out  AB: write address; valid while `we` = 1.
- `wdata`  out  DB: write data, {hi byte, lo byte}; valid while `we` = 1.
- `busy`  out  1: high while a load is in progress.
- `done`  out  1: high after a load has completed, including error completion.
- `err`  out  1: the length header exceeded 2^AB.
- `words_written`  out  AB+1: number of words written in the current or last load.

## Operation

- Reset values: `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, `err`=0, `words_written`=0. State is IDLE.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE. All outputs are registered.
- IDLE/DONE:
  - `rx_done` is ignored.
  - `start`=1 moves to LEN_HI and sets `busy`=1.
  - On that same edge, `done`, `err`, `words_written` and the address counter are cleared.
- LEN_HI: on `rx_done`, capture N[15:8] and go to LEN_LO.
- LEN_LO: on `rx_done`, capture N[7:0]. The next state depends on N:
  - N = 0: go to DONE. Set `done`=1 and `busy`=0. No writes occur.
  - N > 2^AB (2048): go to DONE. Set `err`=1, `done`=1 and `busy`=0. No writes occur.
  - Otherwise: go to DATA_HI.
- DATA_HI: on `rx_done`, capture the hi byte and go to DATA_LO.
- DATA_LO: on `rx_done`, assert `we` for exactly one cycle, with:
  - `wdata` = {hi, rx_data};
  - `waddr` = address counter;
  - `words_written` incremented on the same edge.
  - If this was word N-1, go to DONE, with `done`=1 and `busy`=0 set on the same edge as the final `we`.
  - Otherwise, increment the address counter and go to DATA_HI.
- Address counter: AB bits. The maximum N of 2048 ends at address 2047. The counter never wraps within a load.
- `start` while `busy` is ignored.
- `rx_done` and `start` in the same cycle in IDLE: `start` is taken and the byte is discarded. The header begins with the next strobe.
- `waddr`/`wdata` hold their last values when `we`=0.
- Reset mid-load: all outputs return to their reset values immediately (asynchronous). Partially written memory is not rolled back.

## Timing

- `start` at edge t: `busy`=1 from t.
- Byte strobe at edge t in DATA_LO: `we`=1 during the cycle following edge t, for exactly one cycle.
- Byte-to-write latency: 1 cycle after the lo-byte strobe.
- Strobes on consecutive cycles are accepted without loss. One byte is consumed per strobe in every non-idle state.
- `done` is level, not a pulse. It holds until the next accepted `start` or `reset`.
- Minimum load duration: 2 + 2N strobes after `start`.

## Test plan

- Reset with clock idle: all outputs 0. Assert `reset` mid-load after 3 data bytes: `we`/`busy`/`words_written` return to 0 asynchronously, and a new `start` loads correctly.
- `start`, then bytes 00 03 60 01 63 01 6C 02: three `we` pulses with addr/data 0/0x6001, 1/0x6301, 2/0x6C02. `done`=1 and `busy`=0 coincide with the third pulse; `words_written`=3.
- Header 00 00: no `we`, `done`=1, `err`=0. Header 08 01 (2049): no `we`, `done`=1, `err`=1.
- Header 08 00 followed by 4096 bytes with `rx_done` every cycle: 2048 pulses, last at `waddr`=2047, `words_written`=2048, no dropped byte.
- `start` pulsed mid-load and stray `rx_done` in IDLE/DONE: no effect on state or outputs. `start` coincident with `rx_done`=1 and `rx_data`=0x00 in IDLE, then header 00 01 and word 12 34: single write 0/0x1234.
